rob_param: RTL and testbench
============================

// Module: rob_param
// PURPOSE
//  Parametrised reorder buffer, successor to the fixed 32-entry ROB. Sits between Decoder, RS/ALU, LSB and RF.
//  Allocates in order and accepts N writeback ports. Retires one entry per cycle in order: REG writes RF,
//  STORE is handed to LSB with a valid/ready handshake, BRANCH is checked and a mispredict flushes the pipe.
// PARAMETERS
//  DEPTH     32  entries, power of 2, >=4
//  ID_W      5   log2(DEPTH)
//  WB_PORTS  2   writeback ports (RS, LSB, ...)
//  XLEN      32  data width
// PORTS
//  clk_in          in   1              clock
//  rst_in          in   1              asynchronous, active-high reset
//  rdy_in          in   1              low = freeze all state; rf_we and st_commit_valid forced 0
//  alloc_valid     in   1              decoder pushes an entry this cycle
//  alloc_ready     out  1              (count<DEPTH) && state==RUN
//  alloc_id        out  ID_W           tail; ROB id given to the pushed entry
//  alloc_type      in   2              00 REG, 01 STORE, 10 BRANCH, 11 OTHER (retire, no write)
//  alloc_rd        in   5              destination register (REG only)
//  alloc_done      in   1              entry already complete (lui/auipc/jal)
//  alloc_value     in   XLEN           result when alloc_done=1
//  alloc_pred      in   1              BRANCH: predicted taken
//  alloc_alt_pc    in   XLEN           BRANCH: restart PC if the prediction is wrong
//  rf_dep_we       out  1              alloc of a REG entry: RF marks alloc_rd dependent on alloc_id
//  wb_valid        in   WB_PORTS       per-port result valid
//  wb_id           in   WB_PORTS*ID_W  per-port ROB id, port p in bits [p*ID_W +: ID_W]
//  wb_value        in   WB_PORTS*XLEN  per-port result; BRANCH: bit0 = actual taken
//  qry1_id/qry2_id in   ID_W           operand lookup
//  qry1_ready/qry2_ready  out  1       entry complete
//  qry1_value/qry2_value  out  XLEN    entry result
//  rf_we           out  1              commit REG this cycle
//  rf_rd           out  5              committed register
//  rf_tag          out  ID_W           head id; RF clears the dependency only if tag matches
//  rf_value        out  XLEN           committed value
//  st_commit_valid out  1              head is a done STORE
//  st_commit_ready in   1              LSB accepts the store
//  head_id         out  ID_W           current head
//  flush           out  1              registered; high exactly 1 cycle on mispredict
//  flush_pc        out  XLEN           restart PC, valid while flush=1
// BEHAVIOUR
//  Reset: head=tail=count=0, all busy/done=0, state=RUN, flush=0, flush_pc=0. All outputs derive from this state.
//  FSM RUN<->FLUSH. RUN: push when alloc_valid&&alloc_ready: entry busy=1, done=alloc_done, tail++ (mod DEPTH).
//  Writeback: port p with wb_valid sets done=1, value=wb_value only if the entry is busy; otherwise ignored.
//   Two ports hitting the same id in one cycle: higher port index wins. Writeback to tail in the same cycle as its alloc: writeback wins.
//  Retire (combinational from head, pop on the edge). Condition: count>0 && done[head].
//   REG: rf_we=1, pop. OTHER: pop.
//   STORE: st_commit_valid=1; pop only when st_commit_ready=1, else hold (no other retire).
//   BRANCH: pop. If value[0]!=pred: flush<=1, flush_pc<=alt_pc, state<=FLUSH; allocs that cycle are still accepted but get discarded.
//  FLUSH (1 cycle): alloc_ready=0, writebacks ignored, no retire. Clear busy/done, head=tail=count=0, flush<=0, ->RUN.
//  count: +1 on push only, -1 on pop only, unchanged on both. Ids wrap at DEPTH. Full: alloc_ready=0 even if head pops this cycle.
//  Reset mid-flush or mid-store-handshake returns to the reset state immediately.
// CONFIGURATION
//  ROB_FWD_EN defined: qry ready/value bypass the same cycle, priority alloc (tail==id) > wb port high..low > array.
//  ROB_FWD_EN undefined: qry reads the array only; a result is visible the cycle after its writeback.
// TESTING
//  1 Reset, alloc REG rd=5 done=1 val=0x1234 -> next cycle rf_we=1, rf_rd=5, rf_value=0x1234, rf_tag=0.
//  2 Fill DEPTH entries, none done -> alloc_ready=0 at count=32. wb id0, next cycle retire -> alloc_ready=1; tail wraps 31->0.
//  3 STORE at head done, st_commit_ready=0 for 3 cycles -> st_commit_valid held, head fixed; ready=1 -> pop, head+1.
//  4 BRANCH pred=1, wb value=0, alt_pc=0x100 -> flush=1 for 1 cycle with flush_pc=0x100; after it head=tail=0, alloc_ready=1.
//  5 wb port0 and port1 both to id3 (0xA, 0xB) -> entry3 value=0xB. wb to a non-busy id -> no change.
//  6 With ROB_FWD_EN: wb id2=0x77 and qry1_id=2 in the same cycle -> qry1_ready=1, qry1_value=0x77. Without it: qry1_ready=0 that cycle, 1 the next.

Source files
------------

// File: rtl/rob_param.sv
// Parametrised reorder buffer.
// In-order allocate, N-port writeback, in-order single-entry retire to RF / LSB / branch check.
// Optional build macro ROB_FWD_EN: operand queries bypass same-cycle alloc/writeback data.
module rob_param #(
    parameter int DEPTH    = 32,
    parameter int ID_W     = 5,
    parameter int WB_PORTS = 2,
    parameter int XLEN     = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    output logic [ID_W-1:0]          alloc_id,
    input  logic [1:0]               alloc_type,
    input  logic [4:0]               alloc_rd,
    input  logic                     alloc_done,
    input  logic [XLEN-1:0]          alloc_value,
    input  logic                     alloc_pred,
    input  logic [XLEN-1:0]          alloc_alt_pc,
    output logic                     rf_dep_we,
    input  logic [WB_PORTS-1:0]      wb_valid,
    input  logic [WB_PORTS*ID_W-1:0] wb_id,
    input  logic [WB_PORTS*XLEN-1:0] wb_value,
    input  logic [ID_W-1:0]          qry1_id,
    input  logic [ID_W-1:0]          qry2_id,
    output logic                     qry1_ready,
    output logic                     qry2_ready,
    output logic [XLEN-1:0]          qry1_value,
    output logic [XLEN-1:0]          qry2_value,
    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [ID_W-1:0]          rf_tag,
    output logic [XLEN-1:0]          rf_value,
    output logic                     st_commit_valid,
    input  logic                     st_commit_ready,
    output logic [ID_W-1:0]          head_id,
    output logic                     flush,
    output logic [XLEN-1:0]          flush_pc
);
    localparam logic [1:0] T_REG    = 2'b00;
    localparam logic [1:0] T_STORE  = 2'b01;
    localparam logic [1:0] T_BRANCH = 2'b10;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    localparam logic [ID_W:0] FULL = (ID_W+1)'(DEPTH);

    logic [0:0]                  state_q, state_d;
    logic [ID_W-1:0]             head_q, head_d, tail_q, tail_d;
    logic [ID_W:0]               count_q, count_d;
    logic                        flush_q, flush_d;
    logic [XLEN-1:0]             flush_pc_q, flush_pc_d;
    logic [DEPTH-1:0]            busy_q, busy_d, done_q, done_d, pred_q, pred_d;
    logic [DEPTH-1:0][1:0]       type_q, type_d;
    logic [DEPTH-1:0][4:0]       rd_q, rd_d;
    logic [DEPTH-1:0][XLEN-1:0]  value_q, value_d, alt_pc_q, alt_pc_d;

    logic       can_retire, push, pop, mispredict;
    logic [1:0] head_type;

    // Retire decision is purely combinational from the head entry; the pop happens on the edge.
    always_comb begin
        head_type  = type_q[head_q];
        can_retire = (state_q == S_RUN) && (count_q != '0) && done_q[head_q];
        push       = rdy_in && alloc_valid && alloc_ready;
        pop        = rdy_in && can_retire && ((head_type != T_STORE) || st_commit_ready);
        mispredict = pop && (head_type == T_BRANCH) && (value_q[head_q][0] != pred_q[head_q]);
    end

    assign alloc_ready     = (count_q < FULL) && (state_q == S_RUN);
    assign alloc_id        = tail_q;
    assign rf_dep_we       = push && (alloc_type == T_REG);
    assign rf_we           = rdy_in && can_retire && (head_type == T_REG);
    assign st_commit_valid = rdy_in && can_retire && (head_type == T_STORE);
    assign rf_rd           = rd_q[head_q];
    assign rf_tag          = head_q;
    assign rf_value        = value_q[head_q];
    assign head_id         = head_q;
    assign flush           = flush_q;
    assign flush_pc        = flush_pc_q;

    // Next state: order inside RUN is pop, then alloc, then writeback, so a writeback to the
    // entry being allocated this cycle lands on top of the alloc data.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        flush_d    = flush_q;
        flush_pc_d = flush_pc_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pred_d     = pred_q;
        type_d     = type_q;
        rd_d       = rd_q;
        value_d    = value_q;
        alt_pc_d   = alt_pc_q;
        if (rdy_in) begin
            if (state_q == S_FLUSH) begin
                busy_d  = '0;
                done_d  = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                flush_d = 1'b0;
                state_d = S_RUN;
            end else begin
                if (pop) begin
                    busy_d[head_q] = 1'b0;
                    done_d[head_q] = 1'b0;
                    head_d         = head_q + ID_W'(1);
                end
                if (mispredict) begin
                    flush_d    = 1'b1;
                    flush_pc_d = alt_pc_q[head_q];
                    state_d    = S_FLUSH;
                end
                if (push) begin
                    busy_d[tail_q]   = 1'b1;
                    done_d[tail_q]   = alloc_done;
                    type_d[tail_q]   = alloc_type;
                    rd_d[tail_q]     = alloc_rd;
                    value_d[tail_q]  = alloc_value;
                    pred_d[tail_q]   = alloc_pred;
                    alt_pc_d[tail_q] = alloc_alt_pc;
                    tail_d           = tail_q + ID_W'(1);
                end
                // Ascending port order: the highest port hitting an id is written last and wins.
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_valid[p] && busy_d[wb_id[p*ID_W +: ID_W]]) begin
                        done_d[wb_id[p*ID_W +: ID_W]]  = 1'b1;
                        value_d[wb_id[p*ID_W +: ID_W]] = wb_value[p*XLEN +: XLEN];
                    end
                end
                if (push && !pop)
                    count_d = count_q + (ID_W+1)'(1);
                else if (pop && !push)
                    count_d = count_q - (ID_W+1)'(1);
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
            busy_q     <= '0;
            done_q     <= '0;
            pred_q     <= '0;
            type_q     <= '0;
            rd_q       <= '0;
            value_q    <= '0;
            alt_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pred_q     <= pred_d;
            type_q     <= type_d;
            rd_q       <= rd_d;
            value_q    <= value_d;
            alt_pc_q   <= alt_pc_d;
        end
    end

    logic [1:0][ID_W-1:0] q_id;
    logic [1:0]           q_rdy;
    logic [1:0][XLEN-1:0] q_val;

    assign q_id = {qry2_id, qry1_id};

    // Operand lookup; with forwarding, alloc beats writeback ports (high..low) beats the array.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            q_rdy[g] = done_q[q_id[g]];
            q_val[g] = value_q[q_id[g]];
`ifdef ROB_FWD_EN
            if (rdy_in && (state_q == S_RUN)) begin
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_valid[p] && (wb_id[p*ID_W +: ID_W] == q_id[g]) &&
                        (busy_q[q_id[g]] || (push && (tail_q == q_id[g])))) begin
                        q_rdy[g] = 1'b1;
                        q_val[g] = wb_value[p*XLEN +: XLEN];
                    end
                end
                if (push && (tail_q == q_id[g])) begin
                    q_rdy[g] = alloc_done;
                    q_val[g] = alloc_value;
                end
            end
`endif
        end
    end

    assign qry1_ready = q_rdy[0];
    assign qry1_value = q_val[0];
    assign qry2_ready = q_rdy[1];
    assign qry2_value = q_val[1];

endmodule

// File: tb/tb_rob_param.sv
// Directed self-checking bench for rob_param (DEPTH=32, WB_PORTS=2, XLEN=32).
module tb_rob_param;
    localparam int DEPTH = 32, ID_W = 5, WB_PORTS = 2, XLEN = 32;

    logic                     clk_in = 1'b0;
    logic                     rst_in, rdy_in;
    logic                     alloc_valid, alloc_ready;
    logic [ID_W-1:0]          alloc_id;
    logic [1:0]               alloc_type;
    logic [4:0]               alloc_rd;
    logic                     alloc_done, alloc_pred;
    logic [XLEN-1:0]          alloc_value, alloc_alt_pc;
    logic                     rf_dep_we;
    logic [WB_PORTS-1:0]      wb_valid;
    logic [WB_PORTS*ID_W-1:0] wb_id;
    logic [WB_PORTS*XLEN-1:0] wb_value;
    logic [ID_W-1:0]          qry1_id, qry2_id;
    logic                     qry1_ready, qry2_ready;
    logic [XLEN-1:0]          qry1_value, qry2_value;
    logic                     rf_we;
    logic [4:0]               rf_rd;
    logic [ID_W-1:0]          rf_tag, head_id;
    logic [XLEN-1:0]          rf_value, flush_pc;
    logic                     st_commit_valid, st_commit_ready, flush;

    int checks = 0;
    int failures = 0;

    rob_param #(.DEPTH(DEPTH), .ID_W(ID_W), .WB_PORTS(WB_PORTS), .XLEN(XLEN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .alloc_type(alloc_type), .alloc_rd(alloc_rd), .alloc_done(alloc_done),
        .alloc_value(alloc_value), .alloc_pred(alloc_pred), .alloc_alt_pc(alloc_alt_pc),
        .rf_dep_we(rf_dep_we), .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
        .qry1_id(qry1_id), .qry2_id(qry2_id), .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
        .qry1_value(qry1_value), .qry2_value(qry2_value),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_tag(rf_tag), .rf_value(rf_value),
        .st_commit_valid(st_commit_valid), .st_commit_ready(st_commit_ready),
        .head_id(head_id), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk_in = ~clk_in;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic idle();
        alloc_valid = 0; alloc_type = 2'b11; alloc_rd = 0; alloc_done = 0; alloc_value = 0;
        alloc_pred = 0; alloc_alt_pc = 0; wb_valid = 0; wb_id = 0; wb_value = 0;
        qry1_id = 0; qry2_id = 0; st_commit_ready = 0; rdy_in = 1;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1;
        repeat (2) @(negedge clk_in);
        rst_in = 0;
    endtask

    task automatic set_alloc(input logic [1:0] t, input logic [4:0] rd, input logic d,
                             input logic [XLEN-1:0] v, input logic pr, input logic [XLEN-1:0] alt);
        alloc_valid = 1; alloc_type = t; alloc_rd = rd; alloc_done = d;
        alloc_value = v; alloc_pred = pr; alloc_alt_pc = alt;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1;
        @(negedge clk_in); #1;
        checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL rst_alloc_ready got=%0h exp=1", alloc_ready); end
        checks++; if (alloc_id !== 5'd0) begin failures++; $display("FAIL rst_alloc_id got=%0h exp=0", alloc_id); end
        checks++; if (head_id !== 5'd0) begin failures++; $display("FAIL rst_head got=%0h exp=0", head_id); end
        checks++; if (flush !== 1'b0 || flush_pc !== 32'h0) begin failures++; $display("FAIL rst_flush got=%0h/%0h exp=0/0", flush, flush_pc); end
        checks++; if (rf_we !== 1'b0 || st_commit_valid !== 1'b0) begin failures++; $display("FAIL rst_commit got=%0h/%0h exp=0/0", rf_we, st_commit_valid); end
        @(negedge clk_in);
        rst_in = 0;
    endtask

    task automatic test_reg_commit();
        do_reset();
        set_alloc(2'b00, 5'd5, 1'b1, 32'h1234, 1'b0, 32'h0);
        #1;
        checks++; if (rf_dep_we !== 1'b1) begin failures++; $display("FAIL reg_dep_we got=%0h exp=1", rf_dep_we); end
        @(negedge clk_in); idle(); #1;
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL reg_rf_we got=%0h exp=1", rf_we); end
        checks++; if (rf_rd !== 5'd5) begin failures++; $display("FAIL reg_rf_rd got=%0h exp=5", rf_rd); end
        checks++; if (rf_value !== 32'h1234) begin failures++; $display("FAIL reg_rf_value got=%0h exp=1234", rf_value); end
        checks++; if (rf_tag !== 5'd0) begin failures++; $display("FAIL reg_rf_tag got=%0h exp=0", rf_tag); end
        @(negedge clk_in); #1;
        checks++; if (rf_we !== 1'b0 || head_id !== 5'd1) begin failures++; $display("FAIL reg_after got=%0h/%0h exp=0/1", rf_we, head_id); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(2'b11, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
            @(negedge clk_in);
        end
        idle(); #1;
        checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0h exp=0", alloc_ready); end
        checks++; if (alloc_id !== 5'd0) begin failures++; $display("FAIL full_tail_wrap got=%0h exp=0", alloc_id); end
        wb_valid = 2'b01; wb_id = {5'd0, 5'd0}; wb_value = 0;
        @(negedge clk_in); idle(); #1;
        checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL full_ready_popping got=%0h exp=0", alloc_ready); end
        @(negedge clk_in); #1;
        checks++; if (alloc_ready !== 1'b1 || head_id !== 5'd1) begin failures++; $display("FAIL full_after_pop got=%0h/%0h exp=1/1", alloc_ready, head_id); end
    endtask

    task automatic test_store();
        do_reset();
        set_alloc(2'b01, 5'd0, 1'b1, 32'h0, 1'b0, 32'h0);
        @(negedge clk_in); idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (st_commit_valid !== 1'b1 || head_id !== 5'd0) begin failures++; $display("FAIL st_hold%0d got=%0h/%0h exp=1/0", c, st_commit_valid, head_id); end
            @(negedge clk_in);
        end
        st_commit_ready = 1; #1;
        checks++; if (st_commit_valid !== 1'b1 || rf_we !== 1'b0) begin failures++; $display("FAIL st_handshake got=%0h/%0h exp=1/0", st_commit_valid, rf_we); end
        @(negedge clk_in); st_commit_ready = 0; #1;
        checks++; if (st_commit_valid !== 1'b0 || head_id !== 5'd1) begin failures++; $display("FAIL st_pop got=%0h/%0h exp=0/1", st_commit_valid, head_id); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        set_alloc(2'b10, 5'd0, 1'b0, 32'h0, 1'b1, 32'h100);
        @(negedge clk_in);
        set_alloc(2'b00, 5'd7, 1'b1, 32'h55, 1'b0, 32'h0);
        wb_valid = 2'b01; wb_id = {5'd0, 5'd0}; wb_value = 0;
        @(negedge clk_in); idle(); #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL br_preflush got=%0h exp=0", flush); end
        @(negedge clk_in); #1;
        checks++; if (flush !== 1'b1 || flush_pc !== 32'h100) begin failures++; $display("FAIL br_flush got=%0h/%0h exp=1/100", flush, flush_pc); end
        checks++; if (alloc_ready !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL br_flush_block got=%0h/%0h exp=0/0", alloc_ready, rf_we); end
        @(negedge clk_in); #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL br_flush_len got=%0h exp=0", flush); end
        checks++; if (head_id !== 5'd0 || alloc_id !== 5'd0 || alloc_ready !== 1'b1) begin failures++; $display("FAIL br_after got=%0h/%0h/%0h exp=0/0/1", head_id, alloc_id, alloc_ready); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL br_discard got=%0h exp=0", rf_we); end
    endtask

    task automatic test_wb_priority();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(2'b00, 5'd1, 1'b0, 32'h0, 1'b0, 32'h0);
            @(negedge clk_in);
        end
        idle();
        wb_valid = 2'b11; wb_id = {5'd3, 5'd3}; wb_value = {32'hB, 32'hA};
        @(negedge clk_in); idle(); qry1_id = 5'd3; #1;
        checks++; if (qry1_ready !== 1'b1 || qry1_value !== 32'hB) begin failures++; $display("FAIL wb_hi_wins got=%0h/%0h exp=1/b", qry1_ready, qry1_value); end
        wb_valid = 2'b01; wb_id = {5'd0, 5'd10}; wb_value = {32'h0, 32'h55};
        @(negedge clk_in); idle(); qry2_id = 5'd10; #1;
        checks++; if (qry2_ready !== 1'b0 || qry2_value !== 32'h0) begin failures++; $display("FAIL wb_not_busy got=%0h/%0h exp=0/0", qry2_ready, qry2_value); end
        checks++; if (rf_we !== 1'b0 || head_id !== 5'd0) begin failures++; $display("FAIL wb_head_wait got=%0h/%0h exp=0/0", rf_we, head_id); end
    endtask

    // Relies on ids 0..3 being busy from test_wb_priority.
    task automatic test_forward();
        wb_valid = 2'b10; wb_id = {5'd2, 5'd0}; wb_value = {32'h77, 32'h0}; qry1_id = 5'd2; #1;
`ifdef ROB_FWD_EN
        checks++; if (qry1_ready !== 1'b1 || qry1_value !== 32'h77) begin failures++; $display("FAIL fwd_same got=%0h/%0h exp=1/77", qry1_ready, qry1_value); end
`else
        checks++; if (qry1_ready !== 1'b0) begin failures++; $display("FAIL fwd_same got=%0h exp=0", qry1_ready); end
`endif
        @(negedge clk_in); idle(); qry1_id = 5'd2; #1;
        checks++; if (qry1_ready !== 1'b1 || qry1_value !== 32'h77) begin failures++; $display("FAIL fwd_next got=%0h/%0h exp=1/77", qry1_ready, qry1_value); end
    endtask

    task automatic test_freeze();
        do_reset();
        set_alloc(2'b00, 5'd9, 1'b1, 32'h42, 1'b0, 32'h0);
        @(negedge clk_in); idle(); rdy_in = 0; #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL frz_rf_we got=%0h exp=0", rf_we); end
        repeat (2) @(negedge clk_in); #1;
        checks++; if (head_id !== 5'd0 || alloc_id !== 5'd1) begin failures++; $display("FAIL frz_hold got=%0h/%0h exp=0/1", head_id, alloc_id); end
        rdy_in = 1; #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_value !== 32'h42) begin failures++; $display("FAIL frz_resume got=%0h/%0h/%0h exp=1/9/42", rf_we, rf_rd, rf_value); end
        @(negedge clk_in); #1;
        checks++; if (head_id !== 5'd1) begin failures++; $display("FAIL frz_pop got=%0h exp=1", head_id); end
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        set_alloc(2'b01, 5'd0, 1'b1, 32'h0, 1'b0, 32'h0);
        @(negedge clk_in); idle(); #1;
        rst_in = 1; #1;
        checks++; if (st_commit_valid !== 1'b0 || alloc_id !== 5'd0) begin failures++; $display("FAIL rst_mid_store got=%0h/%0h exp=0/0", st_commit_valid, alloc_id); end
        @(negedge clk_in); rst_in = 0;
    endtask

    initial begin
        rst_in = 1;
        idle();
        test_reset();
        test_reg_commit();
        test_full_wrap();
        test_store();
        test_branch_flush();
        test_wb_priority();
        test_forward();
        test_freeze();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
